// File: rtl/mem_stage.sv
// Memory stage: RV32I loads/stores over a req/gnt/rvalid data bus; ALU results
// pass through to register-file write-back with one cycle of latency.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              ex_is_load_i,
  input  logic              ex_is_store_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [31:0]       ex_result_i,
  input  logic [31:0]       ex_store_data_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              ex_wb_en_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              fault_o,
  output logic [1:0]        fault_cause_o,
  output logic [ADDR_W-1:0] fault_addr_o,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: an EX packet moves when ex_valid_i & ex_ready_o at a rising edge;
  // a bus request moves when dmem_req_o & dmem_gnt_i; load data arrives with
  // dmem_rvalid_i, which is honoured only while waiting for it.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    WAIT_RDATA = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              op_load_q;
  logic [2:0]        op_f3_q;
  logic [1:0]        op_lane_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic [31:0]       op_wdata_q;
  logic [3:0]        op_be_q;
  logic [4:0]        op_rd_q;

  logic              xfer;
  logic              is_mem;
  logic              width_ok;
  logic              misaligned;
  logic              mem_fault;
  logic              mem_go;
  logic [ADDR_W-1:0] ea;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  assign ea     = ex_result_i[ADDR_W-1:0];
  assign xfer   = ex_valid_i & ex_ready_o;
  assign is_mem = ex_is_load_i | ex_is_store_i;

  always_comb begin
    width_ok = 1'b0;
    case (ex_funct3_i)
      3'b000, 3'b001, 3'b010: width_ok = 1'b1;
      3'b100, 3'b101:         width_ok = ex_is_load_i;
      default:                width_ok = 1'b0;
    endcase
  end

  // funct3[1:0] encodes the access size for both signed and unsigned loads.
  assign misaligned = ((ex_funct3_i[1:0] == 2'b01) & ea[0]) |
                      ((ex_funct3_i[1:0] == 2'b10) & (ea[1:0] != 2'b00));
  assign mem_fault  = xfer & is_mem & (~width_ok | misaligned);
  assign mem_go     = xfer & is_mem & width_ok & ~misaligned;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_store_data_i;
    case (ex_funct3_i[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ea[1:0];
        st_wdata = {4{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        st_be    = ea[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_store_data_i[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = ex_store_data_i;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata_i[7:0];
    case (op_lane_q)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = op_lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (op_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (mem_go) state_d = REQ;
      REQ:        if (dmem_gnt_i) state_d = op_load_q ? WAIT_RDATA : IDLE;
      WAIT_RDATA: if (dmem_rvalid_i) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_load_q  <= 1'b0;
      op_f3_q    <= 3'b000;
      op_lane_q  <= 2'b00;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
      op_be_q    <= 4'b0000;
      op_rd_q    <= 5'd0;
    end else if (mem_go) begin
      op_load_q  <= ex_is_load_i;
      op_f3_q    <= ex_funct3_i;
      op_lane_q  <= ea[1:0];
      op_addr_q  <= {ea[ADDR_W-1:2], 2'b00};
      op_wdata_q <= st_wdata;
      op_be_q    <= st_be;
      op_rd_q    <= ex_rd_i;
    end
  end

  // Write-back and fault outputs are single-cycle pulses that fall back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_o       <= 1'b0;
      wb_rd_o       <= 5'd0;
      wb_data_o     <= 32'h0;
      fault_o       <= 1'b0;
      fault_cause_o <= 2'b00;
      fault_addr_o  <= '0;
    end else begin
      wb_we_o       <= 1'b0;
      wb_rd_o       <= 5'd0;
      wb_data_o     <= 32'h0;
      fault_o       <= 1'b0;
      fault_cause_o <= 2'b00;
      fault_addr_o  <= '0;
      if (xfer && !is_mem) begin
        wb_we_o   <= ex_wb_en_i & (ex_rd_i != 5'd0);
        wb_rd_o   <= ex_rd_i;
        wb_data_o <= ex_result_i;
      end else if (state_q == WAIT_RDATA && dmem_rvalid_i) begin
        wb_we_o   <= (op_rd_q != 5'd0);
        wb_rd_o   <= op_rd_q;
        wb_data_o <= ld_data;
      end
      if (mem_fault) begin
        fault_o       <= 1'b1;
        fault_cause_o <= !width_ok ? 2'b11 : (ex_is_load_i ? 2'b01 : 2'b10);
        fault_addr_o  <= ea;
      end
    end
  end

  assign ex_ready_o   = (state_q == IDLE);
  assign stall_o      = ~ex_ready_o;
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = dmem_req_o & ~op_load_q;
  assign dmem_addr_o  = dmem_req_o ? op_addr_q : '0;
  assign dmem_wdata_o = dmem_we_o ? op_wdata_q : 32'h0;
  assign dmem_be_o    = dmem_req_o ? (op_load_q ? 4'b1111 : op_be_q) : 4'b0000;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth pipeline stage of the core, directly downstream of the ALU stage; consumes the EX-stage result (ex2wb content) and produces the register-file write-back.
- Performs RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/grant/rvalid data-memory handshake; non-memory results pass through with one-cycle latency.
- Stalls the upstream pipeline while a memory access is outstanding; reports misaligned/illegal-width accesses instead of issuing them.

Parameters:
ADDR_W  32  data-memory byte-address width; data width fixed at 32

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-high reset
ex_valid_i  input  1  EX result valid this cycle
ex_ready_o  output  1  stage accepts EX result (high only in IDLE)
ex_is_load_i  input  1  op is a load
ex_is_store_i  input  1  op is a store (is_load and is_store never both high)
ex_funct3_i  input  3  RV32I width/sign field
ex_result_i  input  32  ALU result; effective address for memory ops
ex_store_data_i  input  32  rs2 value for stores
ex_rd_i  input  5  destination register
ex_wb_en_i  input  1  op writes rd (ignored for stores)
stall_o  output  1  equals ~ex_ready_o
dmem_req_o  output  1  memory request valid
dmem_we_o  output  1  1 = store
dmem_addr_o  output  ADDR_W  word-aligned address (low 2 bits zero)
dmem_wdata_o  output  32  lane-replicated store data
dmem_be_o  output  4  byte strobes
dmem_gnt_i  input  1  request accepted this cycle
dmem_rvalid_i  input  1  load data valid
dmem_rdata_i  input  32  load data word
wb_we_o  output  1  register-file write strobe (one-cycle pulse)
wb_rd_o  output  5  write-back register
wb_data_o  output  32  write-back data
fault_o  output  1  one-cycle fault pulse
fault_cause_o  output  2  01 misaligned load, 10 misaligned store, 11 illegal width
fault_addr_o  output  ADDR_W  faulting effective address

Behaviour:
- Reset (async, any state): state IDLE, all outputs 0 except ex_ready_o=1.
- FSM states: IDLE, REQ, WAIT_RDATA. Transfer occurs when ex_valid_i & ex_ready_o.
- IDLE, non-memory transfer: next cycle wb_we_o=ex_wb_en_i & (rd!=0), wb_rd_o=rd, wb_data_o=ex_result_i; stay IDLE (back-to-back ops at full rate).
- IDLE, memory transfer: validate width. Load widths: 000,001,010,100,101; store widths: 000,001,010; any other → illegal (cause 11). Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0. On fault: next cycle fault_o=1 with cause/addr, no bus request, no write-back, stay IDLE. Illegal width takes priority over misalignment.
- Valid memory transfer: capture op into internal registers; next state REQ.
- REQ: dmem_req_o=1 with stable addr/we/wdata/be until dmem_gnt_i. Store + gnt → IDLE (no write-back). Load + gnt → WAIT_RDATA.
- WAIT_RDATA: on dmem_rvalid_i, next cycle wb_we_o=(rd!=0), wb_data_o=formatted load data; → IDLE. rvalid is sampled only in WAIT_RDATA; memory guarantees rvalid no earlier than the cycle after gnt; rvalid in any other state is ignored.
- Load formatting, lane=addr[1:0]: LB/LBU select byte lane, sign-/zero-extend; LH/LHU select half addr[1], sign-/zero-extend; LW whole word.
- Store: SB be=0001<<lane, wdata={4{byte}}; SH be=0011<<(2*addr[1]), wdata={2{half}}; SW be=1111, wdata=rs2.
- Load to x0: bus access still performed, wb_we_o=0.
- ex_ready_o low in REQ and WAIT_RDATA; upstream holds its packet; ex_valid_i ignored while not ready.
- Reset mid-access: request dropped immediately; a late rvalid after reset is ignored.
- wb_* and fault_* outputs are registered, return to 0 the cycle after each pulse.

Test Plan:
- Reset then ADD result 0x0000_1234, rd=5, wb_en=1 -> next cycle wb_we_o=1, wb_rd_o=5, wb_data_o=0x0000_1234; rd=0 variant -> wb_we_o=0.
- LB addr 0x103, gnt after 2 wait cycles, rdata 0x80AB_CDEF -> dmem_addr_o=0x100, req held 3 cycles, ex_ready_o low throughout, wb_data_o=0xFFFF_FF80; LBU -> 0x0000_0080.
- SH addr 0x0202, rs2 0x1234_5678 -> dmem_be_o=1100, dmem_wdata_o=0x5678_5678, dmem_we_o=1, no wb pulse, IDLE after gnt.
- LW addr 0x0001 -> fault_o=1, cause 01, fault_addr_o=0x0001, dmem_req_o never asserted; load funct3 011 -> cause 11.
- Load in WAIT_RDATA, assert rst, then rvalid 2 cycles later -> all outputs 0, no wb_we_o pulse, ex_ready_o=1.
- Back-to-back: ALU op, LW 0x40 (gnt+rvalid next cycles, data 0xDEADBEEF), ALU op -> three wb pulses in order with correct data; third op held until load completes.
